// File: rtl/qoi_decoder.sv
// Streaming QOI chunk decoder: encoded bytes in, RGBA pixels out, one image per start_i.
// Optional end-marker check after the last pixel: define QOI_DEC_END_CHECK_EN.
module qoi_decoder #(
  parameter int CNT_W = 30,
  parameter int IDX_N = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] size_i,
  input  logic [7:0]       in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [31:0]      px_o,
  output logic             px_valid_o,
  input  logic             px_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] count_o
);

  // state  | meaning
  // IDLE   | waiting for start_i
  // OP     | accepting an op byte
  // ARG    | accepting argument bytes of RGB/RGBA/LUMA
  // EMIT   | presenting one decoded pixel
  // RUN    | presenting run_left copies of prev_px
  // END    | consuming the 8-byte end marker (optional)
  // DONE   | image finished, waits for next start_i
  typedef enum logic [2:0] {
    S_IDLE,
    S_OP,
    S_ARG,
    S_EMIT,
    S_RUN,
`ifdef QOI_DEC_END_CHECK_EN
    S_END,
`endif
    S_DONE
  } state_t;

  typedef enum logic [1:0] {K_RGB, K_RGBA, K_LUMA} kind_t;

`ifdef QOI_DEC_END_CHECK_EN
  localparam state_t S_FINAL = S_END;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  state_t           state_q, state_d;
  kind_t            kind_q;
  logic [CNT_W-1:0] size_q, count_q, count_inc;
  logic [31:0]      prev_px, px_q;
  logic [31:0]      idx_mem [IDX_N];
  logic [IDX_N-1:0] idx_vld;
  logic [1:0]       arg_cnt, arg_last;
  logic [7:0]       luma_dg;
  logic [6:0]       run_left;
  logic             run_first;
  logic             err_q;
  logic             start_ok, byte_xfer, px_xfer, last_px;
  logic             is_rgb, is_rgba, is_index, is_diff, is_luma, is_run;
  logic [5:0]       px_hash;
  logic [31:0]      diff_px, luma_px;
  logic [7:0]       luma_dr, luma_db;
`ifdef QOI_DEC_END_CHECK_EN
  logic [2:0]       end_cnt;
`endif

  function automatic logic [5:0] qoi_hash(input logic [31:0] p);
    logic [7:0] h;
    h = p[7:0] * 8'd3 + p[15:8] * 8'd5 + p[23:16] * 8'd7 + p[31:24] * 8'd11;
    return h[5:0];
  endfunction

  always_comb begin
    is_rgb   = (in_data_i == 8'hFE);
    is_rgba  = (in_data_i == 8'hFF);
    is_index = (in_data_i[7:6] == 2'b00);
    is_diff  = (in_data_i[7:6] == 2'b01);
    is_luma  = (in_data_i[7:6] == 2'b10);
    is_run   = (in_data_i[7:6] == 2'b11) && !is_rgb && !is_rgba;
  end

  always_comb begin
    diff_px = {prev_px[31:24],
               prev_px[23:16] + {6'd0, in_data_i[1:0]} - 8'd2,
               prev_px[15:8]  + {6'd0, in_data_i[3:2]} - 8'd2,
               prev_px[7:0]   + {6'd0, in_data_i[5:4]} - 8'd2};
    luma_dr = luma_dg + {4'd0, in_data_i[7:4]} - 8'd8;
    luma_db = luma_dg + {4'd0, in_data_i[3:0]} - 8'd8;
    luma_px = {prev_px[31:24],
               prev_px[23:16] + luma_db,
               prev_px[15:8]  + luma_dg,
               prev_px[7:0]   + luma_dr};
  end

  always_comb begin
    case (kind_q)
      K_RGB:   arg_last = 2'd2;
      K_RGBA:  arg_last = 2'd3;
      default: arg_last = 2'd0;
    endcase
  end

  assign count_inc = count_q + CNT_W'(1);
  assign last_px   = (count_inc == size_q);
  assign px_hash   = qoi_hash(px_q);
  assign start_ok  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign byte_xfer = in_valid_i && in_ready_o;
  assign px_xfer   = px_valid_o && px_ready_i;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    px_valid_o = 1'b0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        busy_o = 1'b0;
        done_o = (state_q == S_DONE);
        if (start_i) state_d = (size_i == '0) ? S_DONE : S_OP;
      end
      S_OP: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          if (is_rgb || is_rgba || is_luma) state_d = S_ARG;
          else if (is_run)                  state_d = S_RUN;
          else                              state_d = S_EMIT;
        end
      end
      S_ARG: begin
        in_ready_o = 1'b1;
        if (in_valid_i && (arg_cnt == arg_last)) state_d = S_EMIT;
      end
      S_EMIT: begin
        px_valid_o = 1'b1;
        if (px_ready_i) state_d = last_px ? S_FINAL : S_OP;
      end
      S_RUN: begin
        px_valid_o = 1'b1;
        if (px_ready_i) begin
          if (last_px)                 state_d = S_FINAL;
          else if (run_left == 7'd1)   state_d = S_OP;
        end
      end
`ifdef QOI_DEC_END_CHECK_EN
      S_END: begin
        in_ready_o = 1'b1;
        if (in_valid_i && (end_cnt == 3'd7)) state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q    <= '0;
      count_q   <= '0;
      prev_px   <= '0;
      px_q      <= '0;
      idx_vld   <= '0;
      kind_q    <= K_RGB;
      arg_cnt   <= '0;
      luma_dg   <= '0;
      run_left  <= '0;
      run_first <= 1'b0;
      err_q     <= 1'b0;
`ifdef QOI_DEC_END_CHECK_EN
      end_cnt   <= '0;
`endif
      for (int i = 0; i < IDX_N; i++) idx_mem[i] <= '0;
    end else begin
      if (start_ok) begin
        size_q  <= size_i;
        count_q <= '0;
        err_q   <= 1'b0;
        prev_px <= 32'hFF00_0000;
        idx_vld <= '0;
`ifdef QOI_DEC_END_CHECK_EN
        end_cnt <= '0;
`endif
      end

      if ((state_q == S_OP) && byte_xfer) begin
        arg_cnt <= '0;
        px_q    <= prev_px;
        if (is_rgb) kind_q <= K_RGB;
        else if (is_rgba) kind_q <= K_RGBA;
        else if (is_luma) begin
          kind_q  <= K_LUMA;
          luma_dg <= {2'b00, in_data_i[5:0]} - 8'd32;
        end else if (is_index) begin
          px_q <= idx_vld[in_data_i[5:0]] ? idx_mem[in_data_i[5:0]] : 32'h0;
        end else if (is_diff) begin
          px_q <= diff_px;
        end else begin
          run_left  <= {1'b0, in_data_i[5:0]} + 7'd1;
          run_first <= 1'b1;
        end
      end

      if ((state_q == S_ARG) && byte_xfer) begin
        arg_cnt <= arg_cnt + 2'd1;
        if (kind_q == K_LUMA) px_q <= luma_px;
        else begin
          case (arg_cnt)
            2'd0:    px_q[7:0]   <= in_data_i;
            2'd1:    px_q[15:8]  <= in_data_i;
            2'd2:    px_q[23:16] <= in_data_i;
            default: px_q[31:24] <= in_data_i;
          endcase
        end
      end

      if ((state_q == S_EMIT) && px_xfer) begin
        prev_px          <= px_q;
        idx_mem[px_hash] <= px_q;
        idx_vld[px_hash] <= 1'b1;
        count_q          <= count_inc;
      end

      // prev_px already holds the run colour, so only the index needs a first-pixel write
      if ((state_q == S_RUN) && px_xfer) begin
        count_q   <= count_inc;
        run_left  <= run_left - 7'd1;
        run_first <= 1'b0;
        if (run_first) begin
          idx_mem[px_hash] <= px_q;
          idx_vld[px_hash] <= 1'b1;
        end
        if (last_px && (run_left != 7'd1)) err_q <= 1'b1;
      end

`ifdef QOI_DEC_END_CHECK_EN
      if ((state_q == S_END) && byte_xfer) begin
        end_cnt <= end_cnt + 3'd1;
        if (in_data_i != ((end_cnt == 3'd7) ? 8'h01 : 8'h00)) err_q <= 1'b1;
      end
`endif
    end
  end

  assign px_o    = px_q;
  assign err_o   = err_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_qoi_decoder.sv
// Directed, table-driven bench for qoi_decoder; honours QOI_DEC_END_CHECK_EN when defined.
`timescale 1ns/1ps
module tb_qoi_decoder;
  localparam int CNT_W = 30;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [CNT_W-1:0] size_i;
  logic [7:0]       in_data_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      px_o;
  logic             px_valid_o;
  logic             px_ready_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [CNT_W-1:0] count_o;

  always #5 clk = ~clk;

  qoi_decoder #(.CNT_W(CNT_W), .IDX_N(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .size_i     (size_i),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .px_o       (px_o),
    .px_valid_o (px_valid_o),
    .px_ready_i (px_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .count_o    (count_o)
  );

  typedef struct {
    string        name;
    int           size;
    int           nb;
    logic [127:0] bytes;     // right-aligned, first byte most significant
    int           npx;
    logic [255:0] px;        // right-aligned, first pixel most significant
    bit           err;
    int           stall_at;  // pixel index to hold px_ready_i low for 3 cycles, -1 = none
    bit           bad_end;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  function automatic vec_t mk(input string name, input int size, input int nb,
                              input logic [127:0] b, input int npx, input logic [255:0] p,
                              input bit err, input int stall_at, input bit bad_end);
    vec_t v;
    v.name = name; v.size = size; v.nb = nb; v.bytes = b; v.npx = npx; v.px = p;
    v.err = err; v.stall_at = stall_at; v.bad_end = bad_end;
    return v;
  endfunction

  function automatic logic [31:0] exp_px(input vec_t v, input int j);
    return v.px[32*(v.npx-1-j) +: 32];
  endfunction

  function automatic logic [7:0] stream_byte(input vec_t v, input int i);
    if (i < v.nb) return v.bytes[8*(v.nb-1-i) +: 8];
    if (i - v.nb == 7) return v.bad_end ? 8'h02 : 8'h01;
    return 8'h00;
  endfunction

  task automatic run_vec(input vec_t v);
    int bi, pj, tot, cyc, stall_left;
    bit stalled, fin;
    bi = 0; pj = 0; cyc = 0; stall_left = 0; stalled = 0; fin = 0;
    tot = v.nb;
`ifdef QOI_DEC_END_CHECK_EN
    if (v.size > 0) tot = tot + 8;
`endif
    @(negedge clk);
    start_i = 1'b1;
    size_i  = CNT_W'(v.size);
    @(negedge clk);
    start_i = 1'b0;
    while (!fin && cyc < 300) begin
      if (done_o) fin = 1;
      else begin
        if (bi < tot) begin
          in_valid_i = 1'b1;
          in_data_i  = stream_byte(v, bi);
          if (in_ready_o) bi++;
        end else in_valid_i = 1'b0;
        if (px_valid_o && pj == v.stall_at && !stalled) begin
          stalled    = 1;
          stall_left = 3;
        end
        if (stall_left > 0) begin
          px_ready_i = 1'b0;
          chk({v.name, " hold_valid"}, 64'(px_valid_o), 64'd1);
          if (pj < v.npx) chk({v.name, " hold_px"}, 64'(px_o), 64'(exp_px(v, pj)));
          stall_left--;
        end else begin
          px_ready_i = 1'b1;
          if (px_valid_o) begin
            if (pj < v.npx) chk($sformatf("%s px%0d", v.name, pj), 64'(px_o), 64'(exp_px(v, pj)));
            pj++;
          end
        end
        cyc++;
        @(negedge clk);
      end
    end
    in_valid_i = 1'b0;
    chk({v.name, " done"},    64'(done_o),  64'd1);
    chk({v.name, " npx"},     64'(pj),      64'(v.npx));
    chk({v.name, " count"},   64'(count_o), 64'(v.npx));
    chk({v.name, " err"},     64'(err_o),   64'(v.err));
    chk({v.name, " busy"},    64'(busy_o),  64'd0);
    chk({v.name, " bytes"},   64'(bi),      64'(tot));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " in_ready"}, 64'(in_ready_o), 64'd0);
    chk({tag, " px"},       64'(px_o),       64'd0);
    chk({tag, " px_valid"}, 64'(px_valid_o), 64'd0);
    chk({tag, " busy"},     64'(busy_o),     64'd0);
    chk({tag, " done"},     64'(done_o),     64'd0);
    chk({tag, " err"},      64'(err_o),      64'd0);
    chk({tag, " count"},    64'(count_o),    64'd0);
  endtask

  task automatic reset_mid_run(input vec_t v);
    int bi, cyc;
    bi = 0; cyc = 0;
    @(negedge clk);
    start_i = 1'b1;
    size_i  = CNT_W'(v.size);
    @(negedge clk);
    start_i = 1'b0;
    while (count_o < CNT_W'(2) && cyc < 200) begin
      if (bi < v.nb) begin
        in_valid_i = 1'b1;
        in_data_i  = stream_byte(v, bi);
        if (in_ready_o) bi++;
      end else in_valid_i = 1'b0;
      px_ready_i = 1'b1;
      cyc++;
      @(negedge clk);
    end
    chk("rst_mid pre_count", 64'(count_o), 64'd2);
    chk("rst_mid pre_valid", 64'(px_valid_o), 64'd1);
    px_ready_i = 1'b0;
    in_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start_i    = 1'b0;
    size_i     = '0;
    in_data_i  = 8'h00;
    in_valid_i = 1'b0;
    px_ready_i = 1'b0;

    vecs.push_back(mk("size1", 1, 4, 128'(32'hFE102030), 1, 256'(32'hFF302010), 0, -1, 0));
    vecs.push_back(mk("diff", 2, 5, 128'(40'hFE1020307B), 2,
                      256'({32'hFF302010, 32'hFF312011}), 0, -1, 0));
    vecs.push_back(mk("run", 5, 6, 128'(48'hFF01020304C3), 5,
                      256'({5{32'h04030201}}), 0, 2, 0));
    vecs.push_back(mk("luma_idx", 3, 7, 128'(56'hFE0A0A0AA2880B), 3,
                      256'({32'hFF0A0A0A, 32'hFF0C0C0C, 32'hFF0A0A0A}), 0, -1, 0));
    vecs.push_back(mk("trunc", 3, 5, 128'(40'hFE010101C9), 3,
                      256'({3{32'hFF010101}}), 1, -1, 0));
    vecs.push_back(mk("neg_luma_diff", 2, 3, 128'(24'h800040), 2,
                      256'({32'hFFD8E0D8, 32'hFFD6DED6}), 0, -1, 0));
    vecs.push_back(mk("rgba_rgb", 2, 9, 128'(72'hFF11223344FE556677), 2,
                      256'({32'h44332211, 32'h44776655}), 0, -1, 0));
    vecs.push_back(mk("idx_cleared", 1, 1, 128'(8'h2A), 1, 256'(32'h00000000), 0, -1, 0));
    vecs.push_back(mk("size0", 0, 0, 128'(8'h00), 0, 256'(32'h0), 0, -1, 0));
`ifdef QOI_DEC_END_CHECK_EN
    vecs.push_back(mk("bad_end", 1, 4, 128'(32'hFE010203), 1, 256'(32'hFF030201), 1, -1, 1));
    vecs.push_back(mk("good_end", 1, 4, 128'(32'hFE010203), 1, 256'(32'hFF030201), 0, -1, 0));
`endif

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k]);

    reset_mid_run(vecs[2]);
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
